// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU, single-cycle ops plus optional iterative multiplier.
// Ports: in_valid/in_ready + x,y,funct in; out_valid/out_ready + result,eq,lt out.
// Macro ALU_SEQ_MUL_EN enables the shift-add multiplier (funct 1000).
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [3:0]       funct,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             eq,
  output logic             lt
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_eq;
  logic             alu_lt;
  logic             is_mul;
  logic             big_y;
  logic             fire;

  // WIDTH is a power of two, so y >= WIDTH iff any bit above the shamt field is set
  assign big_y = |(y >> SHW);

  assign in_ready = ~reset &
                    ((state_q == IDLE) |
                     ((state_q == DONE) & out_ready));
  assign fire     = in_valid & in_ready;

  always_comb begin
    alu_res = '0;
    alu_eq  = 1'b0;
    alu_lt  = 1'b0;
    is_mul  = 1'b0;
    unique case (funct)
      4'b0101: alu_res = x + y;
      4'b0100: alu_res = x - y;
      4'b1110: alu_res = big_y ? '0 : x << y[SHW-1:0];
      4'b0111: alu_res = big_y ? '0 : x >> y[SHW-1:0];
      4'b0001: alu_res = x ^ y;
      4'b0011: alu_res = x & y;
      4'b0010: alu_res = x | y;
      4'b0110: begin
        alu_res = x;
        alu_eq  = (x == y);
        alu_lt  = (x < y);
      end
`ifdef ALU_SEQ_MUL_EN
      4'b1000: is_mul = 1'b1;
`endif
      // SH: y[SHW] selects direction, y[SHW-1:0] the amount
      default: alu_res = y[SHW] ? x >> y[SHW-1:0]
                                : x << y[SHW-1:0];
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mc_q, mc_d;
  logic [WIDTH-1:0] mp_q, mp_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_nx;

  // multiplicand shifts up, multiplier shifts down; high bits fall off
  assign acc_nx = acc_q + (mp_q[0] ? mc_q : '0);
`endif

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
`ifdef ALU_SEQ_MUL_EN
    acc_d   = acc_q;
    mc_d    = mc_q;
    mp_d    = mp_q;
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if ((state_q == DONE) && out_ready) state_d = IDLE;
        if (fire) begin
          if (is_mul) begin
            state_d = BUSY;
`ifdef ALU_SEQ_MUL_EN
            acc_d   = '0;
            mc_d    = x;
            mp_d    = y;
            cnt_d   = '0;
`endif
          end else begin
            state_d = DONE;
            res_d   = alu_res;
            eq_d    = alu_eq;
            lt_d    = alu_lt;
          end
        end
      end
      BUSY: begin
`ifdef ALU_SEQ_MUL_EN
        acc_d = acc_nx;
        mc_d  = mc_q << 1;
        mp_d  = mp_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = DONE;
          res_d   = acc_nx;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      res_q   <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

`ifdef ALU_SEQ_MUL_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      mc_q  <= '0;
      mp_q  <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      mc_q  <= mc_d;
      mp_q  <= mp_d;
      cnt_q <= cnt_d;
    end
  end
`endif

  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign eq        = eq_q;
  assign lt        = lt_q;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width (legal: power of two, 8..32).
REQ-002 SHALL have localparam SHW = clog2(WIDTH), shift-amount field width for op SH.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1, the operand handshake; transfer occurs when both are high on a clk edge.
REQ-006 SHALL have ports x, y input WIDTH each and funct input 4, the operands and opcode, sampled on transfer.
REQ-007 SHALL have ports out_valid output 1 and out_ready input 1, the result handshake.
REQ-008 SHALL have ports result output WIDTH, eq output 1 (x==y) and lt output 1 (x<y unsigned), all registered.

Function
REQ-009 SHALL decode funct as: 0101 add, 0100 sub, 1110 shl x<<y, 0111 shr x>>y, 0001 xor, 0011 and, 0010 or, 0110 cmp, 1000 mul; any other code is SH.
REQ-010 SHALL compute add/sub/mul modulo 2^WIDTH, discarding carry, borrow and high product bits.
REQ-011 SHALL give result 0 for shl/shr when y >= WIDTH.
REQ-012 SHALL for SH shift x right by y[SHW-1:0] when y[SHW]=1, else left by the same amount; all other y bits are ignored.
REQ-013 SHALL for cmp set result=x with eq/lt valid; for every other op eq=0 and lt=0.
REQ-014 SHALL use FSM states IDLE, BUSY and DONE.
REQ-015 SHALL for single-cycle ops (all but mul) go IDLE->DONE on transfer, with out_valid high the next cycle (latency 1).
REQ-016 SHALL for mul go IDLE->BUSY, run iterative shift-add over exactly WIDTH cycles, then BUSY->DONE (out_valid WIDTH+1 cycles after transfer).
REQ-017 SHALL in DONE hold out_valid, result, eq and lt stable until out_ready=1.
REQ-018 SHALL drive in_ready combinationally = (state==IDLE) | (state==DONE & out_ready); it SHALL be 0 in BUSY.
REQ-019 SHALL on DONE with out_ready=1 and a simultaneous input transfer load the new op directly (DONE->DONE or DONE->BUSY), giving back-to-back single-cycle throughput of 1 op/cycle.
REQ-020 SHALL on DONE with out_ready=1 and no transfer return to IDLE with out_valid=0 the next cycle.
REQ-021 SHALL ignore x, y and funct whenever no transfer occurs; inputs changing during BUSY SHALL NOT affect the result.

Reset
REQ-022 SHALL on reset=1 at a clk edge enter IDLE with out_valid=0, result=0, eq=0, lt=0 and the mul accumulator/counter cleared.
REQ-023 SHALL abort an in-progress mul on reset without producing output.
REQ-024 SHALL keep in_ready=0 while reset is asserted.

Configuration
REQ-025 SHALL gate the multiplier with macro ALU_SEQ_MUL_EN.
REQ-026 SHALL with ALU_SEQ_MUL_EN defined implement mul per REQ-016.
REQ-027 SHALL without ALU_SEQ_MUL_EN omit the BUSY datapath and treat funct 1000 as SH (latency 1); BUSY is then never entered.

Verification
REQ-028 SHALL pass: WIDTH=8, add x=0xF0 y=0x20, out_ready=1 -> out_valid one cycle later, result=0x10, eq=0, lt=0.
REQ-029 SHALL pass: cmp x=0x05 y=0x05, then cmp 0x03/0x07 back-to-back -> result 0x05 eq=1 lt=0, then 0x03 eq=0 lt=1, on consecutive cycles.
REQ-030 SHALL pass: SH x=0x81 y=0x0A, then y=0x02 -> 0x20, then 0x04; shl y=9 -> 0x00.
REQ-031 SHALL pass with MUL_EN: mul 0x0D*0x0B (WIDTH=8) -> out_valid exactly 9 cycles after transfer, result=0x8F, in_ready=0 throughout BUSY.
REQ-032 SHALL pass: result held with out_ready=0 for 5 cycles -> out_valid and result stable, in_ready=0; then out_ready=1 -> consumed, IDLE.
REQ-033 SHALL pass: reset asserted on cycle 4 of a mul -> next cycle out_valid=0, result=0, in_ready=1 after deassert; no stale output emitted.
